// File: rtl/vga_pkg.sv
// Screen geometry shared by the VGA pipeline, plus the state encoding of the
// falling-rectangle controller.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned V_ACTIVE = 600;
    localparam int unsigned POS_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FALL   = 2'd1,
        ST_LANDED = 2'd2
    } rect_state_e;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: the history flop is registered and the pulse is
// combinational, so it is high during the cycle whose clk_in edge sees the 0->1 change.
module edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise_c
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig_in;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_c = sig_in & ~prev_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle position controller: follows the mouse, drops under gravity after
// a click, rests on the floor, and returns to tracking on the next click.
module draw_rect_ctl
    import vga_pkg::*;
#(
    parameter int unsigned RECT_H  = 64,
    parameter int unsigned Y_FLOOR = V_ACTIVE,
    parameter int unsigned GRAV    = 1,
    parameter int unsigned V_MAX   = 31
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             vblnk_in,
    input  logic [POS_W-1:0] mouse_xpos,
    input  logic [POS_W-1:0] mouse_ypos,
    input  logic             mouse_left,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             falling
);

    localparam int unsigned VEL_W = 6;
    localparam int unsigned SUM_W = POS_W + 1;
    localparam logic [POS_W-1:0] TOP_Y = POS_W'(Y_FLOOR - RECT_H);

    logic tick_c;
    logic click_c;

    edge_det u_vblnk_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (vblnk_in),
        .rise_c (tick_c)
    );

    edge_det u_click_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (mouse_left),
        .rise_c (click_c)
    );

    rect_state_e      state_q, state_d;
    logic [POS_W-1:0] xpos_q, xpos_d;
    logic [POS_W-1:0] ypos_q, ypos_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic             pending_q, pending_d;
    logic             falling_q, falling_d;

    logic             pend_any_c;
    logic [VEL_W:0]   vel_sum_c;
    logic [VEL_W-1:0] vel_n_c;
    logic [SUM_W-1:0] ypos_sum_c;
    logic [POS_W-1:0] mouse_y_clamp_c;

    // Gravity step and floor/mouse clamps, evaluated every cycle, used on ticks only.
    always_comb begin
        pend_any_c      = pending_q | click_c;
        vel_sum_c       = {1'b0, vel_q} + (VEL_W + 1)'(GRAV);
        vel_n_c         = (vel_sum_c > (VEL_W + 1)'(V_MAX)) ? VEL_W'(V_MAX)
                                                           : vel_sum_c[VEL_W-1:0];
        ypos_sum_c      = {1'b0, ypos_q} + SUM_W'(vel_n_c);
        mouse_y_clamp_c = (mouse_ypos > TOP_Y) ? TOP_Y : mouse_ypos;
    end

    always_comb begin
        state_d   = state_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        vel_d     = vel_q;
        pending_d = pend_any_c;

        if (tick_c) begin
            // Every tick consumes the pending click, whatever the state does with it.
            pending_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pend_any_c) begin
                        state_d = ST_FALL;
                        vel_d   = '0;
                    end else begin
                        xpos_d = mouse_xpos;
                        ypos_d = mouse_y_clamp_c;
                    end
                end
                ST_FALL: begin
                    vel_d = vel_n_c;
                    if (ypos_sum_c >= SUM_W'(TOP_Y)) begin
                        ypos_d  = TOP_Y;
                        state_d = ST_LANDED;
                    end else begin
                        ypos_d = ypos_sum_c[POS_W-1:0];
                    end
                end
                ST_LANDED: begin
                    if (pend_any_c) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        falling_d = (state_d == ST_FALL);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            xpos_q    <= '0;
            ypos_q    <= '0;
            vel_q     <= '0;
            pending_q <= 1'b0;
            falling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            vel_q     <= vel_d;
            pending_q <= pending_d;
            falling_q <= falling_d;
        end
    end

    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign falling = falling_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl: a default instance and a fast-saturating
// instance (GRAV=3, V_MAX=4) driven by the same mouse/vblank stimulus.
module tb_draw_rect_ctl;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        vblnk_in;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [11:0] xpos, ypos, xpos2, ypos2;
    logic        falling, falling2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    draw_rect_ctl dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .xpos       (xpos),
        .ypos       (ypos),
        .falling    (falling)
    );

    draw_rect_ctl #(.GRAV(3), .V_MAX(4)) dut2 (
        .clk_in     (clk_in),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .xpos       (xpos2),
        .ypos       (ypos2),
        .falling    (falling2)
    );

    // One vblank pulse; returns 1 ns after the tick edge has been followed by a quiet edge.
    task automatic do_tick();
        @(negedge clk_in) vblnk_in = 1'b1;
        @(negedge clk_in) vblnk_in = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_click();
        @(negedge clk_in) mouse_left = 1'b1;
        @(negedge clk_in) mouse_left = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk_in) rst = 1'b1;
        @(negedge clk_in) rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        mouse_xpos = 12'd9;
        mouse_ypos = 12'd9;
        do_tick();
        n_checks++;
        if (ypos !== 12'd9) begin
            n_fail++;
            $display("FAIL reset_preload: ypos=%0d expected 9", ypos);
        end
        @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || falling !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: x=%0d y=%0d f=%b expected 0 0 0", xpos, ypos, falling);
        end
        @(negedge clk_in) rst = 1'b0;
    endtask

    task automatic test_tracking();
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd200;
        do_tick();
        n_checks++;
        if (xpos !== 12'd100 || ypos !== 12'd200 || falling !== 1'b0) begin
            n_fail++;
            $display("FAIL track_tick: x=%0d y=%0d f=%b expected 100 200 0", xpos, ypos, falling);
        end
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd400;
        repeat (4) @(posedge clk_in);
        #1;
        n_checks++;
        if (xpos !== 12'd100 || ypos !== 12'd200) begin
            n_fail++;
            $display("FAIL track_hold: x=%0d y=%0d expected 100 200", xpos, ypos);
        end
    endtask

    task automatic test_clamp();
        mouse_ypos = 12'd590;
        do_tick();
        n_checks++;
        if (ypos !== 12'd536) begin
            n_fail++;
            $display("FAIL clamp_590: ypos=%0d expected 536", ypos);
        end
        mouse_ypos = 12'd535;
        do_tick();
        n_checks++;
        if (ypos !== 12'd535) begin
            n_fail++;
            $display("FAIL clamp_535: ypos=%0d expected 535", ypos);
        end
        mouse_ypos = 12'd537;
        do_tick();
        n_checks++;
        if (ypos !== 12'd536 || xpos !== 12'd300) begin
            n_fail++;
            $display("FAIL clamp_537: x=%0d y=%0d expected 300 536", xpos, ypos);
        end
    endtask

    task automatic test_fall();
        int exp_first [4] = '{1, 3, 6, 10};
        int vel = 0;
        int y   = 0;
        bit landed = 1'b0;
        mouse_xpos = 12'd50;
        mouse_ypos = 12'd0;
        do_tick();
        do_click();
        mouse_xpos = 12'd700;
        do_tick();
        n_checks++;
        if (ypos !== 12'd0 || xpos !== 12'd50 || falling !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_entry: x=%0d y=%0d f=%b expected 50 0 1", xpos, ypos, falling);
        end
        for (int i = 0; i < 4; i++) begin
            do_tick();
            vel = vel + 1;
            y   = y + vel;
            n_checks++;
            if (ypos !== 12'(exp_first[i]) || y != exp_first[i]) begin
                n_fail++;
                $display("FAIL fall_step%0d: ypos=%0d expected %0d", i, ypos, exp_first[i]);
            end
        end
        for (int i = 0; i < 40 && !landed; i++) begin
            do_tick();
            vel = (vel + 1 > 31) ? 31 : vel + 1;
            if (y + vel >= 536) begin
                y = 536;
                landed = 1'b1;
            end else begin
                y = y + vel;
            end
            n_checks++;
            if (ypos !== 12'(y) || falling !== !landed || xpos !== 12'd50) begin
                n_fail++;
                $display("FAIL fall_run: x=%0d y=%0d f=%b expected 50 %0d %b", xpos, ypos, falling, y, !landed);
            end
        end
        n_checks++;
        if (!landed || ypos !== 12'd536 || falling !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_land: y=%0d f=%b expected 536 0", ypos, falling);
        end
    endtask

    task automatic test_saturation();
        int exp_first [4] = '{3, 7, 11, 15};
        int y = 0;
        bit landed = 1'b0;
        pulse_reset();
        mouse_xpos = 12'd10;
        mouse_ypos = 12'd0;
        do_tick();
        do_click();
        do_tick();
        n_checks++;
        if (ypos2 !== 12'd0 || falling2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_entry: y=%0d f=%b expected 0 1", ypos2, falling2);
        end
        for (int i = 0; i < 4; i++) begin
            do_tick();
            n_checks++;
            if (ypos2 !== 12'(exp_first[i])) begin
                n_fail++;
                $display("FAIL sat_step%0d: ypos=%0d expected %0d", i, ypos2, exp_first[i]);
            end
        end
        y = 15;
        do_click();
        do_tick();
        y = y + 4;
        n_checks++;
        if (ypos2 !== 12'(y) || falling2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_click_ignored: y=%0d f=%b expected %0d 1", ypos2, falling2, y);
        end
        for (int i = 0; i < 200 && !landed; i++) begin
            do_tick();
            if (y + 4 >= 536) begin
                y = 536;
                landed = 1'b1;
            end else begin
                y = y + 4;
            end
            if (ypos2 !== 12'(y)) begin
                n_checks++;
                n_fail++;
                $display("FAIL sat_run: ypos=%0d expected %0d", ypos2, y);
            end
        end
        n_checks++;
        if (!landed || ypos2 !== 12'd536 || falling2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_land: y=%0d f=%b expected 536 0", ypos2, falling2);
        end
        mouse_xpos = 12'd77;
        mouse_ypos = 12'd88;
        do_tick();
        n_checks++;
        if (ypos2 !== 12'd536 || xpos2 !== 12'd10) begin
            n_fail++;
            $display("FAIL landed_hold: x=%0d y=%0d expected 10 536", xpos2, ypos2);
        end
        do_click();
        do_tick();
        n_checks++;
        if (ypos2 !== 12'd536 || xpos2 !== 12'd10 || falling2 !== 1'b0) begin
            n_fail++;
            $display("FAIL return_tick: x=%0d y=%0d expected 10 536", xpos2, ypos2);
        end
        do_tick();
        n_checks++;
        if (xpos2 !== 12'd77 || ypos2 !== 12'd88) begin
            n_fail++;
            $display("FAIL return_track: x=%0d y=%0d expected 77 88", xpos2, ypos2);
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        mouse_xpos = 12'd20;
        mouse_ypos = 12'd30;
        do_tick();
        @(negedge clk_in);
        vblnk_in   = 1'b1;
        mouse_left = 1'b1;
        @(posedge clk_in);
        #1;
        n_checks++;
        if (falling !== 1'b1 || ypos !== 12'd30 || xpos !== 12'd20) begin
            n_fail++;
            $display("FAIL simul_click_tick: x=%0d y=%0d f=%b expected 20 30 1", xpos, ypos, falling);
        end
        @(negedge clk_in);
        vblnk_in   = 1'b0;
        mouse_left = 1'b0;
        do_tick();
        n_checks++;
        if (ypos !== 12'd31 || falling !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_first_step: y=%0d f=%b expected 31 1", ypos, falling);
        end
        @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || falling !== 1'b0) begin
            n_fail++;
            $display("FAIL midfall_reset: x=%0d y=%0d f=%b expected 0 0 0", xpos, ypos, falling);
        end
        @(negedge clk_in) rst = 1'b0;
        mouse_xpos = 12'd5;
        mouse_ypos = 12'd6;
        do_tick();
        n_checks++;
        if (xpos !== 12'd5 || ypos !== 12'd6 || falling !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_tick: x=%0d y=%0d f=%b expected 5 6 0", xpos, ypos, falling);
        end
    endtask

    initial begin
        rst        = 1'b1;
        vblnk_in   = 1'b0;
        mouse_xpos = '0;
        mouse_ypos = '0;
        mouse_left = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        n_checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || falling !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: x=%0d y=%0d f=%b expected 0 0 0", xpos, ypos, falling);
        end
        @(negedge clk_in) rst = 1'b0;
        test_reset();
        test_tracking();
        test_clamp();
        test_fall();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_rect_ctl.md
DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

Interface
REQ-001 Parameter RECT_H, default 64: rectangle height in pixels, used for floor clamping.
REQ-002 Parameter Y_FLOOR, default 600: first line below the visible area; the rectangle bottom never passes it.
REQ-003 Parameter GRAV, default 1: velocity increment per frame while falling.
REQ-004 Parameter V_MAX, default 31: velocity ceiling in pixels per frame.
REQ-005 clk_in  input  1  pixel clock (40 MHz); the block's only clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 vblnk_in  input  1  vertical blank from the timing pipeline; its rising edge is the frame tick.
REQ-008 mouse_xpos  input  12  mouse X position, already in the clk_in domain.
REQ-009 mouse_ypos  input  12  mouse Y position, already in the clk_in domain.
REQ-010 mouse_left  input  1  left mouse button level.
REQ-011 xpos  output  12  rectangle X position, driven to draw_rect.
REQ-012 ypos  output  12  rectangle Y position, driven to draw_rect.
REQ-013 falling  output  1  high while the state is FALL.

Function
REQ-014 The block SHALL assert the frame tick on the clk_in edge where vblnk_in samples 1 and its registered previous value is 0; xpos, ypos and the state SHALL change only on tick edges.
REQ-015 A click SHALL be a 0->1 edge of registered mouse_left, and it SHALL set a sticky pending flag that the next tick consumes and clears.
REQ-016 A click and a tick on the same edge SHALL count for that tick.
REQ-017 States SHALL be IDLE, FALL and LANDED.
REQ-018 IDLE on tick: xpos <= mouse_xpos and ypos <= min(mouse_ypos, Y_FLOOR-RECT_H).
REQ-019 IDLE on tick with pending set: go to FALL, set vel to 0, and hold xpos/ypos at their current values.
REQ-020 FALL on tick: vel_n = min(vel+GRAV, V_MAX), then ypos <= ypos + vel_n, with xpos frozen.
REQ-021 The sum ypos + vel_n SHALL be computed 13 bits wide; if it is >= Y_FLOOR-RECT_H, ypos <= Y_FLOOR-RECT_H exactly and the state goes to LANDED.
REQ-022 Pending clicks during FALL SHALL be cleared at each tick and ignored.
REQ-023 LANDED SHALL hold xpos/ypos; on a tick with pending set it goes to IDLE, which tracks the mouse from the following tick on.
REQ-024 vel SHALL be 6 bits and SHALL never exceed V_MAX.
REQ-025 falling SHALL be registered and equal (state == FALL).

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, xpos=0, ypos=0, vel=0, pending=0, falling=0 and the edge-detector history to 0.
REQ-027 Reset asserted mid-FALL SHALL abort the fall with no landing clamp applied.
REQ-028 After rst deasserts, the first vblnk_in rising edge SHALL be treated as a normal tick.

Structure
REQ-029 A shared package (vga_pkg) SHALL hold the screen constants H_ACTIVE=800, V_ACTIVE=600 and the position width of 12; Y_FLOOR defaults from V_ACTIVE.
REQ-030 Sub-module edge_det (registered rising-edge detector with clk_in and async rst) SHALL be instantiated twice: once for vblnk_in and once for mouse_left.
REQ-031 The block SHALL sit between MouseCtl/vga_timing and draw_rect, replacing the direct mouse-to-draw_rect xpos/ypos connection.

Verification
REQ-032 Reset: assert rst mid-clock -> xpos=0, ypos=0, falling=0 immediately, without waiting for an edge.
REQ-033 Tracking: mouse (100,200), one vblnk rise -> xpos=100, ypos=200 on the tick edge; mouse changes between ticks -> outputs unchanged.
REQ-034 Clamp: mouse_ypos=590 with RECT_H=64 -> ypos=536 on the next tick.
REQ-035 Fall: ypos=0, 1-cycle click, then ticks -> ypos 0 (entry tick), then 1, 3, 6, 10, ...; on reaching 536 ypos=536 exactly, LANDED, falling=0.
REQ-036 Saturation and return: V_MAX=4, GRAV=3 -> increments 3, 4, 4, ...; click during FALL ignored; click in LANDED -> IDLE, and the next tick copies the mouse position.
REQ-037 Simultaneous and mid-fall reset: click and vblnk rise on the same edge -> FALL that tick; rst during FALL -> IDLE with outputs 0.
